alu_rs_scheduler: RTL
=====================

Name: alu_rs_scheduler

Overview:
Reservation station and issue scheduler for the single-cycle integer/branch ALU in the Tomasulo core. Accepts decoded ops from the dispatcher with operand values or pending ROB tags. Snoops two result buses (ALU and LSB) and issues at most one ready op per cycle into the ALU's registered input interface. Sits between dispatch/ROB and the ALU.

Parameters:
RS_SIZE_BIT, 3, log2 of entry count (8 entries)
ROB_SIZE_BIT, 4, ROB tag width
RS_TYPE_BIT, 5, op-type width: [4]=is_branch, [3:1]=func3, [0]=func7 bit

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous, active-high reset
rdy_in  in  1  global stall; all state frozen when low
clear  in  1  mispredict flush, synchronous
disp_valid  in  1  dispatch strobe
disp_type  in  RS_TYPE_BIT  op type
disp_v1 / disp_v2  in  32  operand values
disp_q1_busy / disp_q2_busy  in  1  operand pending
disp_q1 / disp_q2  in  ROB_SIZE_BIT  producer tags
disp_rob_id  in  ROB_SIZE_BIT  destination tag
cdb0_valid, cdb1_valid  in  1  ALU / LSB broadcast valid
cdb0_rob_id, cdb1_rob_id  in  ROB_SIZE_BIT  broadcast tags
cdb0_val, cdb1_val  in  32  broadcast values
rs_full  out  1  all entries busy
alu_input  out  1  issue strobe to ALU
arith_type  out  RS_TYPE_BIT  issued op type
r1_val / r2_val  out  32  issued operands
inst_rob_id  out  ROB_SIZE_BIT  issued tag

Behaviour:
- Reset (async): all entries free; alu_input, arith_type, r1_val, r2_val, inst_rob_id = 0; rs_full = 0.
- rdy_in low: no dispatch, capture, issue or clear; all outputs hold.
- Entry: busy, type, v1, v2, q1_busy, q2_busy, q1, q2, rob_id.
- rs_full: combinational, high when all 2^RS_SIZE_BIT entries busy, computed from current state (an issue in the same cycle does not count). Dispatcher must not assert disp_valid while rs_full; if it does, the op is dropped and state is unchanged.
- Dispatch: written into the lowest-index free entry. Same-cycle forwarding: a pending operand whose tag matches a valid cdb in that cycle is stored as its value with the busy flag cleared.
- Capture: every busy entry with qN_busy and qN == cdbX_rob_id and cdbX_valid stores cdbX_val and clears qN_busy. Both buses are checked every cycle. cdb0 and cdb1 never carry the same tag.
- Ready: busy && !q1_busy && !q2_busy, evaluated on registered state. An operand captured in cycle N makes the entry issueable in cycle N+1.
- Issue: each posedge with at least one ready entry, the picker selects one. Outputs are registered: alu_input<=1, fields<=entry contents, entry freed. The freed slot can be dispatched into next cycle.
- No ready entry: alu_input<=0, inst_rob_id<=0; the other outputs hold.
- Latency: dispatch with both operands valid at edge N gives alu_input=1 after edge N+1, with the ALU result after edge N+2.
- clear (rdy_in high): all entries freed, alu_input<=0, inst_rob_id<=0. Takes precedence over dispatch, capture and issue in the same cycle.
- Branch ops are treated the same as arithmetic ops; the ALU interprets arith_type[4].

Optional Feature:
ALU_RS_AGE_PICK_EN
- Defined: each entry has a RS_SIZE_BIT-bit age counter, set to 0 on dispatch and incremented (saturating) on every rdy cycle while the entry is busy. The picker issues the ready entry with the greatest age; ties go to the lowest index.
- Undefined: no age state; the picker issues the lowest-index ready entry.

Decomposition:
- Config.v (shared): RS_SIZE_BIT, ROB_SIZE_BIT, RS_TYPE_BIT, and the op-type encodings ADD/SUB/.../BEQ... shared with the ALU and decoder.
- Sub-module alu_rs_picker: combinational select. Inputs: ready vector (and ages when the feature is on). Outputs: found and index. Contains the only code affected by the feature macro.

Test Plan:
- Reset then dispatch ADD, v1=5, v2=7, no pending operands, rob 3 -> after next edge alu_input=1, arith_type=5'b00000, r1=5, r2=7, inst_rob_id=3; following cycle alu_input=0, inst_rob_id=0.
- Dispatch SUB with q1 pending on tag 6 -> no issue. cdb1_valid tag 6 val 0x10 -> issue one cycle later with r1=0x10.
- Dispatch with q2=4 in the same cycle as cdb0 tag 4 val 9 -> entry stored ready, issues next cycle with r2=9.
- Fill 8 entries, all pending -> rs_full=1. Broadcast one tag -> that entry issues and rs_full drops the following cycle. Dispatch while full -> dropped, no entry changes.
- Three ready entries in slots 2, 5, 0 dispatched in that order -> issue order slots 0, 2, 5 without the feature, slots 2, 5, 0 with ALU_RS_AGE_PICK_EN.
- clear asserted with 4 busy entries and a same-cycle disp_valid -> all free, alu_input=0, nothing issues afterwards. rdy_in low for 3 cycles mid-stream -> outputs and entries unchanged.

Source files
------------

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared sizes, op-type encodings and payload structs for the ALU reservation station.
// The optional age picker (ALU_RS_AGE_PICK_EN) lives in alu_rs_picker.
package alu_rs_scheduler_pkg;

  localparam int unsigned RS_SIZE_BIT  = 3;
  localparam int unsigned ROB_SIZE_BIT = 4;
  localparam int unsigned RS_TYPE_BIT  = 5;
  localparam int unsigned RS_SIZE      = 1 << RS_SIZE_BIT;
  localparam int unsigned XLEN         = 32;

  // [4]=is_branch, [3:1]=func3, [0]=func7 bit
  typedef enum logic [RS_TYPE_BIT-1:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_SLL  = 5'b00010,
    OP_SLT  = 5'b00100,
    OP_SLTU = 5'b00110,
    OP_XOR  = 5'b01000,
    OP_SRL  = 5'b01010,
    OP_SRA  = 5'b01011,
    OP_OR   = 5'b01100,
    OP_AND  = 5'b01110,
    OP_BEQ  = 5'b10000,
    OP_BNE  = 5'b10010,
    OP_BLT  = 5'b11000,
    OP_BGE  = 5'b11010,
    OP_BLTU = 5'b11100,
    OP_BGEU = 5'b11110
  } alu_op_e;

  typedef struct packed {
    logic                    valid;
    logic [ROB_SIZE_BIT-1:0] rob_id;
    logic [XLEN-1:0]         val;
  } cdb_t;

  typedef struct packed {
    logic                    busy;
    logic [ROB_SIZE_BIT-1:0] tag;
    logic [XLEN-1:0]         val;
  } rs_opnd_t;

  typedef struct packed {
    logic                    busy;
    logic [RS_TYPE_BIT-1:0]  op_type;
    rs_opnd_t                src1;
    rs_opnd_t                src2;
    logic [ROB_SIZE_BIT-1:0] rob_id;
  } rs_entry_t;

  // Resolve a pending operand against both result buses (tags never collide across buses).
  function automatic rs_opnd_t snoop(rs_opnd_t o, cdb_t c0, cdb_t c1);
    rs_opnd_t r;
    r = o;
    if (o.busy && c0.valid && (c0.rob_id == o.tag)) begin
      r.busy = 1'b0;
      r.val  = c0.val;
    end else if (o.busy && c1.valid && (c1.rob_id == o.tag)) begin
      r.busy = 1'b0;
      r.val  = c1.val;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_picker.sv
// Issue select for the ALU reservation station.
// ALU_RS_AGE_PICK_EN: oldest ready entry wins (ties to lowest index); otherwise lowest ready index.
module alu_rs_picker
  import alu_rs_scheduler_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic [RS_SIZE-1:0]     busy,
  input  logic [RS_SIZE-1:0]     alloc,
  input  logic [RS_SIZE-1:0]     ready,
  output logic                   found,
  output logic [RS_SIZE_BIT-1:0] index
);

`ifdef ALU_RS_AGE_PICK_EN
  logic [RS_SIZE_BIT-1:0] age [RS_SIZE];
  logic [RS_SIZE_BIT-1:0] best;

  // Saturating per-entry age, zeroed when the slot is (re)allocated
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) age[i] <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (clear || alloc[i])                begin age[i] <= '0;              end
        else if (busy[i] && (age[i] != '1))   begin age[i] <= age[i] + 1'b1;   end
      end
    end
  end

  always_comb begin
    found = 1'b0;
    index = '0;
    best  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && (!found || (age[i] > best))) begin
        found = 1'b1;
        index = RS_SIZE_BIT'(i);
        best  = age[i];
      end
    end
  end
`else
  logic unused_age_ctl;
  assign unused_age_ctl = ^{clk_in, rst_in, rdy_in, clear, busy, alloc};

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && !found) begin
        found = 1'b1;
        index = RS_SIZE_BIT'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_rs_scheduler.sv
// Reservation station + single-issue scheduler feeding the integer/branch ALU.
// Picker policy selectable with ALU_RS_AGE_PICK_EN (see alu_rs_picker).
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  input  logic                    disp_valid,
  input  logic [RS_TYPE_BIT-1:0]  disp_type,
  input  logic [XLEN-1:0]         disp_v1,
  input  logic [XLEN-1:0]         disp_v2,
  input  logic                    disp_q1_busy,
  input  logic                    disp_q2_busy,
  input  logic [ROB_SIZE_BIT-1:0] disp_q1,
  input  logic [ROB_SIZE_BIT-1:0] disp_q2,
  input  logic [ROB_SIZE_BIT-1:0] disp_rob_id,
  input  logic                    cdb0_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb0_rob_id,
  input  logic [XLEN-1:0]         cdb0_val,
  input  logic                    cdb1_valid,
  input  logic [ROB_SIZE_BIT-1:0] cdb1_rob_id,
  input  logic [XLEN-1:0]         cdb1_val,
  output logic                    rs_full,
  output logic                    alu_input,
  output logic [RS_TYPE_BIT-1:0]  arith_type,
  output logic [XLEN-1:0]         r1_val,
  output logic [XLEN-1:0]         r2_val,
  output logic [ROB_SIZE_BIT-1:0] inst_rob_id
);

  rs_entry_t              ent [RS_SIZE];
  logic [RS_SIZE-1:0]     busy_vec;
  logic [RS_SIZE-1:0]     ready_vec;
  logic [RS_SIZE-1:0]     alloc_oh;
  logic                   alloc_found;
  logic [RS_SIZE_BIT-1:0] alloc_idx;
  logic                   disp_fire;
  logic                   pick_found;
  logic [RS_SIZE_BIT-1:0] pick_idx;
  cdb_t                   cdb0;
  cdb_t                   cdb1;
  rs_opnd_t               d_src1;
  rs_opnd_t               d_src2;

  assign cdb0   = '{valid: cdb0_valid, rob_id: cdb0_rob_id, val: cdb0_val};
  assign cdb1   = '{valid: cdb1_valid, rob_id: cdb1_rob_id, val: cdb1_val};
  assign d_src1 = snoop('{busy: disp_q1_busy, tag: disp_q1, val: disp_v1}, cdb0, cdb1);
  assign d_src2 = snoop('{busy: disp_q2_busy, tag: disp_q2, val: disp_v2}, cdb0, cdb1);

  // Occupancy and readiness from registered state only
  always_comb begin
    busy_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      busy_vec[i]  = ent[i].busy;
      ready_vec[i] = ent[i].busy && !ent[i].src1.busy && !ent[i].src2.busy;
    end
  end

  assign rs_full = &busy_vec;

  // Lowest-index free slot for dispatch
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy_vec[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = RS_SIZE_BIT'(i);
      end
    end
  end

  assign disp_fire = rdy_in && !clear && disp_valid && alloc_found;
  assign alloc_oh  = disp_fire ? (RS_SIZE'(1) << alloc_idx) : '0;

  alu_rs_picker u_picker (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .busy   (busy_vec),
    .alloc  (alloc_oh),
    .ready  (ready_vec),
    .found  (pick_found),
    .index  (pick_idx)
  );

  // Entry storage, wakeup and registered issue port; clear overrides everything else
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      alu_input   <= 1'b0;
      arith_type  <= '0;
      r1_val      <= '0;
      r2_val      <= '0;
      inst_rob_id <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
        alu_input   <= 1'b0;
        inst_rob_id <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (ent[i].busy) begin
            ent[i].src1 <= snoop(ent[i].src1, cdb0, cdb1);
            ent[i].src2 <= snoop(ent[i].src2, cdb0, cdb1);
          end
        end
        if (pick_found) begin
          alu_input          <= 1'b1;
          arith_type         <= ent[pick_idx].op_type;
          r1_val             <= ent[pick_idx].src1.val;
          r2_val             <= ent[pick_idx].src2.val;
          inst_rob_id        <= ent[pick_idx].rob_id;
          ent[pick_idx].busy <= 1'b0;
        end else begin
          alu_input   <= 1'b0;
          inst_rob_id <= '0;
        end
        if (disp_fire) begin
          ent[alloc_idx] <= '{busy: 1'b1, op_type: disp_type, src1: d_src1,
                              src2: d_src2, rob_id: disp_rob_id};
        end
      end
    end
  end

endmodule
